arcade_input_mux: RTL

//  Per-player control merger between hps_io/joy_db9md/joy_db15 and the game core. For each of

---
 rtl/arcade_input_mux_if.sv | 18 +
 rtl/arcade_input_mux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mux_if.sv
// Player-control bundle between the joystick/keyboard sources (master) and arcade_input_mux (slave).
interface arcade_input_mux_if #(
  parameter int PLAYERS = 2,
  parameter int BTNS    = 8
);
  logic [16*PLAYERS-1:0]   usb_joy;
  logic [16*PLAYERS-1:0]   db_joy;
  logic [1:0]              db_sel;
  logic [10:0]             ps2_key;
  logic [BTNS*PLAYERS-1:0] btn_out;
  logic [PLAYERS-1:0]      coin_out;
  logic                    osd_combo;

  modport master (output usb_joy, db_joy, db_sel, ps2_key,
                  input  btn_out, coin_out, osd_combo);
  modport slave  (input  usb_joy, db_joy, db_sel, ps2_key,
                  output btn_out, coin_out, osd_combo);
endinterface

// File: rtl/arcade_input_mux.sv
// Per-player USB/UserIO joystick select with PS/2 keys, per-button debounce (DEBOUNCE_CYC+2 latency),
// coin pulse stretcher and OSD combo detector; no backpressure. MAME_KEYS_EN adds MAME-style keys.
module arcade_input_mux #(
  parameter int PLAYERS        = 2,
  parameter int BTNS           = 8,
  parameter int DEBOUNCE_CYC   = 1024,
  parameter int COIN_PULSE_CYC = 65536,
  parameter int COMBO_HOLD_CYC = 22000000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  arcade_input_mux_if.slave bus
);
  localparam int N   = BTNS * PLAYERS;
  localparam int DCW = $clog2(DEBOUNCE_CYC + 2);
  localparam int PCW = $clog2(COIN_PULSE_CYC + 2);
  localparam int HCW = $clog2(COMBO_HOLD_CYC + 2);
  localparam logic [DCW-1:0] DEB_MAX   = DCW'(DEBOUNCE_CYC);
  localparam logic [PCW-1:0] COIN_LOAD = PCW'(COIN_PULSE_CYC);
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(COMBO_HOLD_CYC);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(COMBO_HOLD_CYC - 1);

  localparam int K_UP = 0, K_DOWN = 1, K_LEFT = 2, K_RIGHT = 3;
  localparam int K_SPC = 4, K_CTL = 5, K_F1 = 6, K_F2 = 7;
`ifdef MAME_KEYS_EN
  localparam int K_1 = 8, K_5 = 9, K_2 = 10, K_6 = 11, K_R = 12, K_F = 13;
  localparam int K_D = 14, K_G = 15, K_A = 16, K_S = 17;
  localparam int KW = 18;
`else
  localparam int KW = 8;
`endif

  function automatic logic [BTNS-1:0] map_db(input logic [15:0] w);
    logic [BTNS-1:0] b;
    b      = '0;
    b[5:0] = w[5:0];
    b[6]   = w[10];
    b[7]   = w[11] | (w[10] & w[5]);
    for (int i = 8; i < BTNS; i++) b[i] = w[i-2];
    return b;
  endfunction

  // Keyboard latches; the next-state value feeds the input register so keys see the same latency as pads.
  logic          key_tgl_q, key_evt, key_dn, key_ext;
  logic [7:0]    key_code;
  logic [KW-1:0] keys_q, keys_d;
  logic [BTNS-1:0] kbd_p0, kbd_p1;

  assign key_evt  = bus.ps2_key[10] ^ key_tgl_q;
  assign key_dn   = bus.ps2_key[9];
  assign key_ext  = bus.ps2_key[8];
  assign key_code = bus.ps2_key[7:0];

  always_comb begin
    keys_d = keys_q;
    if (key_evt) begin
      case (key_code)
        8'h75: keys_d[K_UP]    = key_dn;
        8'h72: keys_d[K_DOWN]  = key_dn;
        8'h6b: keys_d[K_LEFT]  = key_dn;
        8'h74: keys_d[K_RIGHT] = key_dn;
        8'h14: keys_d[K_CTL]   = key_dn;
        8'h29: if (!key_ext) keys_d[K_SPC] = key_dn;
        8'h05: if (!key_ext) keys_d[K_F1]  = key_dn;
        8'h06: if (!key_ext) keys_d[K_F2]  = key_dn;
`ifdef MAME_KEYS_EN
        8'h16: if (!key_ext) keys_d[K_1] = key_dn;
        8'h2e: if (!key_ext) keys_d[K_5] = key_dn;
        8'h1e: if (!key_ext) keys_d[K_2] = key_dn;
        8'h36: if (!key_ext) keys_d[K_6] = key_dn;
        8'h2d: if (!key_ext) keys_d[K_R] = key_dn;
        8'h2b: if (!key_ext) keys_d[K_F] = key_dn;
        8'h23: if (!key_ext) keys_d[K_D] = key_dn;
        8'h34: if (!key_ext) keys_d[K_G] = key_dn;
        8'h1c: if (!key_ext) keys_d[K_A] = key_dn;
        8'h1b: if (!key_ext) keys_d[K_S] = key_dn;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    kbd_p0    = '0;
    kbd_p1    = '0;
    kbd_p0[0] = keys_d[K_RIGHT];
    kbd_p0[1] = keys_d[K_LEFT];
    kbd_p0[2] = keys_d[K_DOWN];
    kbd_p0[3] = keys_d[K_UP];
    kbd_p0[4] = keys_d[K_SPC];
    kbd_p0[5] = keys_d[K_CTL];
    kbd_p0[6] = keys_d[K_F1];
    kbd_p1[6] = keys_d[K_F2];
`ifdef MAME_KEYS_EN
    kbd_p0[6] = keys_d[K_F1] | keys_d[K_1];
    kbd_p0[7] = keys_d[K_5];
    kbd_p1[0] = keys_d[K_G];
    kbd_p1[1] = keys_d[K_D];
    kbd_p1[2] = keys_d[K_F];
    kbd_p1[3] = keys_d[K_R];
    kbd_p1[4] = keys_d[K_A];
    kbd_p1[5] = keys_d[K_S];
    kbd_p1[6] = keys_d[K_F2] | keys_d[K_2];
    kbd_p1[7] = keys_d[K_6];
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      key_tgl_q <= 1'b0;
      keys_q    <= '0;
    end else begin
      key_tgl_q <= bus.ps2_key[10];
      keys_q    <= keys_d;
    end
  end

  logic [N-1:0]       joy_sel, kbd_bits, raw_d, raw_q, btn_q;
  logic [DCW-1:0]     db_cnt [N];
  logic [PLAYERS-1:0] coin_bits, coin_prev_q;
  logic [PCW-1:0]     coin_cnt [PLAYERS];

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    localparam int PU = (p == 0) ? 0 : p - 1;
    logic [15:0]     usb_w, usb_prev_w, db_w;
    logic [BTNS-1:0] sel_b;
    logic            unused_w;

    assign usb_w      = bus.usb_joy[16*p +: 16];
    assign usb_prev_w = bus.usb_joy[16*PU +: 16];
    assign db_w       = bus.db_joy[16*p +: 16];
    assign unused_w   = ^{usb_w, usb_prev_w, db_w};

    always_comb begin
      sel_b = usb_w[BTNS-1:0];
      case (bus.db_sel)
        2'd0:    sel_b = usb_w[BTNS-1:0];
        2'd1:    sel_b = (p == 0) ? map_db(db_w) : usb_prev_w[BTNS-1:0];
        default: sel_b = map_db(db_w);
      endcase
    end

    assign joy_sel[BTNS*p +: BTNS] = sel_b;
    if (p == 0) begin : g_kbd0
      assign kbd_bits[BTNS*p +: BTNS] = kbd_p0;
    end else if (p == 1) begin : g_kbd1
      assign kbd_bits[BTNS*p +: BTNS] = kbd_p1;
    end else begin : g_kbd_none
      assign kbd_bits[BTNS*p +: BTNS] = '0;
    end

    assign coin_bits[p]    = btn_q[BTNS*p + 7];
    assign bus.coin_out[p] = (coin_cnt[p] != '0);
  end

  assign raw_d = joy_sel | kbd_bits;

  // Counter restarts on any raw change; output follows the registered sample once it has been stable long enough.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      raw_q <= '0;
      btn_q <= '0;
      for (int i = 0; i < N; i++) db_cnt[i] <= '0;
    end else begin
      raw_q <= raw_d;
      for (int i = 0; i < N; i++) begin
        if (raw_d[i] != raw_q[i]) db_cnt[i] <= '0;
        else if (db_cnt[i] != DEB_MAX) db_cnt[i] <= db_cnt[i] + DCW'(1);
        if (db_cnt[i] == DEB_MAX && raw_q[i] != btn_q[i]) btn_q[i] <= raw_q[i];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      coin_prev_q <= '0;
      for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= '0;
    end else begin
      coin_prev_q <= coin_bits;
      for (int p = 0; p < PLAYERS; p++) begin
        if (coin_cnt[p] != '0) coin_cnt[p] <= coin_cnt[p] - PCW'(1);
        else if (coin_bits[p] && !coin_prev_q[p]) coin_cnt[p] <= COIN_LOAD;
      end
    end
  end

  logic           combo, osd_q;
  logic [HCW-1:0] hold_cnt;

  assign combo = (bus.db_sel != 2'd0) && bus.db_joy[10] && bus.db_joy[11];

  always_ff @(posedge clk_sys) begin
    if (!reset_n || !combo) begin
      hold_cnt <= '0;
      osd_q    <= 1'b0;
    end else begin
      if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HCW'(1);
      osd_q <= (hold_cnt >= HOLD_LAST);
    end
  end

  assign bus.btn_out   = btn_q;
  assign bus.osd_combo = osd_q;
endmodule
